// File: rtl/meas_pkg.sv
// rtl/meas_pkg.sv - shared types and defaults for the interval meter
package meas_pkg;

    // 180 MHz system clock
    localparam int CLK_PER_MS_DEFAULT = 180000;

    typedef enum logic {
        IDLE,
        MEASURE
    } meas_state_t;

    typedef logic [15:0] ms_t;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - input synchronizer with rising-edge detector
//
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-high reset
//   d_in     asynchronous input
//   rise_out one-cycle pulse on a synchronized rising edge
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], d_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise_out = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/interval_meter.sv
// rtl/interval_meter.sv - measures rise-to-rise interval of an async input in ms
//
// Ports:
//   clk_in      system clock
//   rst_in      synchronous active-high reset
//   sig_in      asynchronous measured signal
//   meas_ms     measured interval in whole ms
//   meas_valid  result available
//   meas_ready  consumer accepts the result
//   meas_ovf    interval reached MAX_MS without a closing edge
//   overrun     one-cycle pulse when an unaccepted result is overwritten
//   busy        high while measuring
module interval_meter
    import meas_pkg::*;
#(
    parameter int CLK_PER_MS  = CLK_PER_MS_DEFAULT,
    parameter int MS_W        = 16,
    parameter int MAX_MS      = 2**MS_W - 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            sig_in,
    output logic [MS_W-1:0] meas_ms,
    output logic            meas_valid,
    input  logic            meas_ready,
    output logic            meas_ovf,
    output logic            overrun,
    output logic            busy
);

    localparam int PRESC_W = $clog2(CLK_PER_MS);
    localparam logic [PRESC_W-1:0] PRESC_LAST    = PRESC_W'(CLK_PER_MS - 1);
    // The cycle on which a rise is seen is already count 0 of the new
    // interval, so the counter resumes at 1 and meas_ms = floor(cycles/CLK_PER_MS).
    localparam logic [PRESC_W-1:0] PRESC_RESTART = PRESC_W'(1);
    localparam logic [MS_W-1:0]    MS_LIMIT      = MS_W'(MAX_MS);

    meas_state_t         r_state, w_state_nxt;
    logic [PRESC_W-1:0]  r_presc, w_presc_nxt;
    logic [MS_W-1:0]     r_ms_cnt, w_ms_cnt_nxt;
    logic [MS_W-1:0]     r_meas_ms;
    logic                r_meas_valid;
    logic                r_meas_ovf;
    logic                r_overrun;

    logic                w_rise;
    logic                w_wrap;
    logic                w_load;
    logic [MS_W-1:0]     w_load_ms;
    logic                w_load_ovf;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .d_in     (sig_in),
        .rise_out (w_rise)
    );

    assign w_wrap = (r_presc == PRESC_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_ms_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_ms_cnt <= w_ms_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_ms_cnt_nxt = r_ms_cnt;
        w_load       = 1'b0;
        w_load_ms    = '0;
        w_load_ovf   = 1'b0;
        case (r_state)
            IDLE: begin
                w_presc_nxt  = '0;
                w_ms_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                    w_presc_nxt = PRESC_RESTART;
                end
            end
            MEASURE: begin
                // A rise beats a simultaneous wrap: report the pre-increment count.
                if (w_rise) begin
                    w_load       = 1'b1;
                    w_load_ms    = r_ms_cnt;
                    w_presc_nxt  = PRESC_RESTART;
                    w_ms_cnt_nxt = '0;
                end else if (w_wrap) begin
                    w_presc_nxt = '0;
                    if (r_ms_cnt == MS_LIMIT) begin
                        w_load       = 1'b1;
                        w_load_ms    = MS_LIMIT;
                        w_load_ovf   = 1'b1;
                        w_state_nxt  = IDLE;
                        w_ms_cnt_nxt = '0;
                    end else begin
                        w_ms_cnt_nxt = r_ms_cnt + 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_meas_ms    <= '0;
            r_meas_valid <= 1'b0;
            r_meas_ovf   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                r_meas_ms    <= w_load_ms;
                r_meas_ovf   <= w_load_ovf;
                r_meas_valid <= 1'b1;
                r_overrun    <= r_meas_valid & ~meas_ready;
            end else if (r_meas_valid && meas_ready) begin
                r_meas_valid <= 1'b0;
            end
        end
    end

    assign meas_ms    = r_meas_ms;
    assign meas_valid = r_meas_valid;
    assign meas_ovf   = r_meas_ovf;
    assign overrun    = r_overrun;
    assign busy       = (r_state == MEASURE);

endmodule
